vcve2_mem_arbiter: RTL and testbench
====================================

VCVE2_MEM_ARBITER -- requirements
Module: vcve2_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, meaning the maximum number of granted transactions awaiting rvalid (legal range 1..8).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have instr_req_i (in, 1), instr_addr_i (in, 32), instr_gnt_o (out, 1), instr_rvalid_o (out, 1), instr_rdata_o (out, 32), instr_err_o (out, 1): the core fetch port.
REQ-005 SHALL have data_req_i (in, 1), data_we_i (in, 1), data_be_i (in, 4), data_addr_i (in, 32), data_wdata_i (in, 32), data_gnt_o (out, 1), data_rvalid_o (out, 1), data_rdata_o (out, 32), data_err_o (out, 1): the core LSU port.
REQ-006 SHALL have mem_req_o (out, 1), mem_we_o (out, 1), mem_be_o (out, 4), mem_addr_o (out, 32), mem_wdata_o (out, 32), mem_gnt_i (in, 1), mem_rvalid_i (in, 1), mem_rdata_i (in, 32), mem_err_i (in, 1): the shared single-port memory bus.
REQ-007 SHALL have busy_o (out, 1): high when any transaction is outstanding or a request is presented.
REQ-008 SHALL have proto_err_o (out, 1): sticky flag set by an unexpected mem_rvalid_i.

Function
REQ-009 SHALL pass req and gnt combinationally, with zero-cycle latency, between the selected requester and the mem port.
REQ-010 SHALL hold a 2-state selector: FREE and LOCKED (with owner INSTR or DATA).
REQ-011 In FREE, with outstanding count < MaxOutstanding, SHALL select a requester and drive mem_req_o=1 in the same cycle; if neither requests, SHALL drive mem_req_o=0.
REQ-012 SHALL make the FREE tie-break data-first when both request (feature REQ-026 overrides).
REQ-013 If mem_req_o=1 and mem_gnt_i=0, SHALL enter LOCKED on the selected owner; LOCKED SHALL present only that owner until mem_gnt_i=1, then return to FREE.
REQ-014 The owner's gnt output SHALL equal mem_gnt_i while the owner is presented; the other requester's gnt SHALL be 0.
REQ-015 With instr selected, SHALL drive mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0 and mem_addr_o=instr_addr_i; with data selected, all data_* request fields SHALL pass through.
REQ-016 SHALL push a 1-bit source tag (0 instr, 1 data) into a MaxOutstanding-deep FIFO on mem_req_o && mem_gnt_i.
REQ-017 SHALL pop the FIFO on mem_rvalid_i.
REQ-018 A simultaneous push and pop SHALL leave the count unchanged, with FIFO ordering preserved; pointers SHALL wrap modulo MaxOutstanding.
REQ-019 SHALL assert instr_rvalid_o = mem_rvalid_i && head tag==0, and data_rvalid_o = mem_rvalid_i && head tag==1.
REQ-020 SHALL fan out mem_rdata_i and mem_err_i to both rdata/err outputs unqualified; consumers qualify them with rvalid.
REQ-021 When count == MaxOutstanding, SHALL hold mem_req_o=0 in FREE and both gnt outputs at 0; a pop in that cycle SHALL NOT enable a request until the next cycle.
REQ-022 On mem_rvalid_i with an empty FIFO, SHALL set proto_err_o, assert no rvalid output and leave count at 0.

Reset
REQ-023 On rst_i=1, SHALL asynchronously clear the selector to FREE, count and pointers to 0, proto_err_o to 0, and round-robin priority to data-first.
REQ-024 During reset, SHALL drive all outputs combinationally from the cleared state: mem_req_o=0, both gnt=0, both rvalid=0, busy_o=0.
REQ-025 Reset asserted mid-transaction SHALL discard outstanding tags; rvalids arriving after reset SHALL be handled per REQ-022.

Configuration
REQ-026 With macro VCVE2_ARB_ROUND_ROBIN_EN defined, the FREE tie-break SHALL favour the requester not granted most recently, updated on each grant; without it, fixed data-first priority SHALL apply and no priority state SHALL exist.

Verification
REQ-027 Both reqs high in cycle 0, mem_gnt_i=1 -> data_gnt_o=1, instr_gnt_o=0, mem_addr_o=data_addr_i; tag 1 pushed.
REQ-028 instr_req_i=1 at 0x80, mem_gnt_i low for 3 cycles, data_req_i rising in cycle 1 -> mem_addr_o stays 0x80 until grant; data granted on a later cycle.
REQ-029 Grant instr then data, then rvalid twice with rdata 0x11111111 and 0x22222222 -> instr_rvalid_o gets the first, data_rvalid_o the second.
REQ-030 MaxOutstanding=2, two grants without rvalid -> mem_req_o=0 despite requests; rvalid -> requests resume on the next cycle.
REQ-031 mem_rvalid_i pulse with no outstanding transaction -> proto_err_o=1 persisting until rst_i; no rvalid output asserted.
REQ-032 With VCVE2_ARB_ROUND_ROBIN_EN, both reqs held and gnt always 1 -> grants alternate data, instr, data, instr.

Source files
------------

// File: rtl/vcve2_mem_arbiter.sv
// vcve2_mem_arbiter: shares one single-port memory bus between the core fetch and LSU ports.
// Optional macro VCVE2_ARB_ROUND_ROBIN_EN selects round-robin tie-break instead of fixed data-first.
module vcve2_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,

  output logic        busy_o,
  output logic        proto_err_o
);

  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned Depth = 1 << PtrW;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  localparam logic [0:0] ST_FREE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      r_state;
  logic            r_owner_data;
  logic [CntW-1:0] r_count;
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [Depth-1:0] r_tags;
  logic            r_proto_err;

  logic w_sel_data;
  logic w_req;
  logic w_full;
  logic w_empty;
  logic w_head_data;
  logic w_push;
  logic w_pop;
  logic w_stall;
  logic w_prio_data;

  assign w_full      = (r_count == MaxCnt);
  assign w_empty     = (r_count == '0);
  assign w_head_data = r_tags[r_rptr];

  always_comb begin
    w_sel_data = 1'b0;
    w_req      = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_sel_data = r_owner_data;
      w_req      = r_owner_data ? data_req_i : instr_req_i;
    end else if (!w_full) begin
      w_sel_data = data_req_i && (!instr_req_i || w_prio_data);
      w_req      = instr_req_i || data_req_i;
    end
  end

  assign mem_req_o   = w_req && !rst_i;
  assign mem_we_o    = w_sel_data ? data_we_i    : 1'b0;
  assign mem_be_o    = w_sel_data ? data_be_i    : 4'hF;
  assign mem_addr_o  = w_sel_data ? data_addr_i  : instr_addr_i;
  assign mem_wdata_o = w_sel_data ? data_wdata_i : '0;

  assign instr_gnt_o = mem_req_o && !w_sel_data && mem_gnt_i;
  assign data_gnt_o  = mem_req_o &&  w_sel_data && mem_gnt_i;

  assign w_push  = mem_req_o && mem_gnt_i;
  assign w_stall = mem_req_o && !mem_gnt_i;
  // A response with nothing outstanding is flagged, never routed.
  assign w_pop   = mem_rvalid_i && !w_empty;

  assign instr_rvalid_o = w_pop && !w_head_data && !rst_i;
  assign data_rvalid_o  = w_pop &&  w_head_data && !rst_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;

  assign busy_o      = (!w_empty || instr_req_i || data_req_i) && !rst_i;
  assign proto_err_o = r_proto_err;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_FREE;
      r_owner_data <= 1'b0;
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state <= w_stall ? ST_LOCKED : ST_FREE;
      if (w_stall) begin
        r_owner_data <= w_sel_data;
      end
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (mem_rvalid_i && w_empty) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_tags[r_wptr] <= w_sel_data;
    end
  end

`ifdef VCVE2_ARB_ROUND_ROBIN_EN
  logic r_prio_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prio_data <= 1'b1;
    end else if (w_push) begin
      r_prio_data <= !w_sel_data;
    end
  end

  assign w_prio_data = r_prio_data;
`else
  assign w_prio_data = 1'b1;
`endif

endmodule

// File: tb/tb_vcve2_mem_arbiter.sv
// Scoreboard bench for vcve2_mem_arbiter: a transaction-level model predicts grants and
// response routing; a monitor pops expectations whenever the DUT shows a gnt or rvalid.
module tb_vcve2_mem_arbiter;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0, data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o, proto_err_o;

  vcve2_mem_arbiter #(.MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    int          src;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  gnt_t exp_gnt_q[$];
  rsp_t exp_rsp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Core-side pending requests (held until granted) and transaction-level model state.
  bit          i_pend, d_pend;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        d_we;
  logic [3:0]  d_be;
  int          m_tags[$];
  bit          m_lock;
  int          m_lock_src;
  int          m_last;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_tags.delete();
    m_lock = 0;
    m_lock_src = 0;
    m_last = 0;
    i_pend = 0;
    d_pend = 0;
  endfunction

  task automatic step(input bit wi, input logic [31:0] ia, input bit wd, input logic [31:0] da,
                      input logic dwe, input logic [3:0] dbe, input logic [31:0] dwd,
                      input bit g, input bit rv, input logic [31:0] rd, input logic re);
    int   sel;
    int   pref;
    gnt_t eg;
    rsp_t er;
    @(posedge clk); #1;
    if (!i_pend && wi) begin i_pend = 1; i_addr = ia; end
    if (!d_pend && wd) begin d_pend = 1; d_addr = da; d_we = dwe; d_be = dbe; d_wdata = dwd; end
    instr_req_i  = i_pend;  instr_addr_i = i_pend ? i_addr : 32'h0;
    data_req_i   = d_pend;  data_addr_i  = d_pend ? d_addr : 32'h0;
    data_we_i    = d_pend ? d_we : 1'b0;
    data_be_i    = d_pend ? d_be : 4'h0;
    data_wdata_i = d_pend ? d_wdata : 32'h0;
    mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = re;

`ifdef VCVE2_ARB_ROUND_ROBIN_EN
    pref = (m_last == 0) ? 1 : 0;
`else
    pref = 1;
`endif
    sel = -1;
    if (m_tags.size() < MAXO) begin
      if (m_lock)               sel = m_lock_src;
      else if (i_pend && d_pend) sel = pref;
      else if (d_pend)          sel = 1;
      else if (i_pend)          sel = 0;
    end
    m_lock = 0;
    if (sel >= 0 && !g) begin
      m_lock = 1;
      m_lock_src = sel;
    end
    if (rv && m_tags.size() > 0) begin
      er.src = m_tags.pop_front(); er.rdata = rd; er.err = re;
      exp_rsp_q.push_back(er);
    end
    if (sel >= 0 && g) begin
      eg.src   = sel;
      eg.addr  = (sel == 1) ? d_addr : i_addr;
      eg.we    = (sel == 1) ? d_we : 1'b0;
      eg.be    = (sel == 1) ? d_be : 4'hF;
      eg.wdata = (sel == 1) ? d_wdata : 32'h0;
      exp_gnt_q.push_back(eg);
      m_tags.push_back(sel);
      m_last = sel;
      if (sel == 1) d_pend = 0; else i_pend = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rv);
    step(0, 0, 0, 0, 0, 0, 0, 0, rv, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    check("gnt_queue_drained", 64'(exp_gnt_q.size()), 0);
    check("rsp_queue_drained", 64'(exp_rsp_q.size()), 0);
    exp_gnt_q.delete();
    exp_rsp_q.delete();
    rst_i = 1; instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    #2;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_instr_gnt", instr_gnt_o, 0);
    check("rst_data_gnt", data_gnt_o, 0);
    check("rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
    check("rst_busy", busy_o, 0);
    check("rst_proto_err", proto_err_o, 0);
    @(posedge clk); #1;
    instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    model_reset();
    rst_i = 0;
    @(negedge clk);
  endtask

  // Monitor: consumes expectations only when the DUT presents a grant or a response.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (instr_gnt_o || data_gnt_o) begin
        check("gnt_single_owner", {instr_gnt_o, data_gnt_o} == 2'b11, 0);
        check("gnt_expected", exp_gnt_q.size() != 0, 1);
        if (exp_gnt_q.size() != 0) begin
          gnt_t e;
          e = exp_gnt_q.pop_front();
          check("gnt_src", 64'(data_gnt_o), 64'(e.src));
          check("gnt_addr", mem_addr_o, e.addr);
          check("gnt_we", mem_we_o, e.we);
          check("gnt_be", mem_be_o, e.be);
          check("gnt_wdata", mem_wdata_o, e.wdata);
        end
      end
      if (instr_rvalid_o || data_rvalid_o) begin
        check("rsp_single_owner", {instr_rvalid_o, data_rvalid_o} == 2'b11, 0);
        check("rsp_expected", exp_rsp_q.size() != 0, 1);
        if (exp_rsp_q.size() != 0) begin
          rsp_t r;
          r = exp_rsp_q.pop_front();
          check("rsp_src", 64'(data_rvalid_o), 64'(r.src));
          check("rsp_rdata", data_rvalid_o ? data_rdata_o : instr_rdata_o, r.rdata);
          check("rsp_err", data_rvalid_o ? data_err_o : instr_err_o, r.err);
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // Both request in the first cycle with an immediate grant: data wins.
    step(1, 32'h200, 1, 32'h1000, 1, 4'h3, 32'hDEAD, 1, 0, 0, 0);
    check("both_req_data_gnt", data_gnt_o, 1);
    check("both_req_instr_gnt", instr_gnt_o, 0);
    check("both_req_addr", mem_addr_o, 32'h1000);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA5A5A5A5, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A5A5A, 0);
    do_reset();

    // A stalled instr request holds the bus until granted.
    step(1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("lock_addr_c0", mem_addr_o, 32'h80);
    step(0, 0, 1, 32'h3000, 0, 4'hF, 0, 0, 0, 0, 0);
    check("lock_addr_c1", mem_addr_o, 32'h80);
    check("lock_data_gnt_c1", data_gnt_o, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("lock_addr_c2", mem_addr_o, 32'h80);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("lock_instr_gnt", instr_gnt_o, 1);
    check("lock_addr_gnt", mem_addr_o, 32'h80);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("lock_then_data_gnt", data_gnt_o, 1);
    check("lock_then_data_addr", mem_addr_o, 32'h3000);
    do_reset();

    // In-order routing plus the outstanding limit.
    step(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("order_instr_gnt", instr_gnt_o, 1);
    step(0, 0, 1, 32'h20, 1, 4'h1, 32'h77, 1, 0, 0, 0);
    check("order_data_gnt", data_gnt_o, 1);
    step(1, 32'h30, 1, 32'h40, 0, 4'hF, 0, 1, 0, 0, 0);
    check("full_mem_req", mem_req_o, 0);
    check("full_gnts", {instr_gnt_o, data_gnt_o}, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h11111111, 0);
    check("full_pop_same_cycle_req", mem_req_o, 0);
    check("first_rsp_instr", instr_rvalid_o, 1);
    check("first_rsp_not_data", data_rvalid_o, 0);
    check("first_rsp_rdata", instr_rdata_o, 32'h11111111);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h22222222, 0);
    check("resume_mem_req", mem_req_o, 1);
    check("second_rsp_data", data_rvalid_o, 1);
    check("second_rsp_not_instr", instr_rvalid_o, 0);
    check("second_rsp_rdata", data_rdata_o, 32'h22222222);
    do_reset();

    // Spurious response: sticky protocol error, nothing routed.
    idle(1);
    check("spurious_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
    for (int k = 0; k < 3; k++) begin
      idle(0);
      check("proto_err_sticky", proto_err_o, 1);
      check("spurious_count_zero_busy", busy_o, 0);
    end
    do_reset();
    check("proto_err_cleared", proto_err_o, 0);

    // Tie-break under continuous contention.
    for (int k = 0; k < 4; k++) begin
      step(1, 32'h100 + k, 1, 32'h900 + k, 0, 4'hF, 0, 1, k > 0, 32'h0, 0);
`ifdef VCVE2_ARB_ROUND_ROBIN_EN
      check("tiebreak_data_gnt", data_gnt_o, (k % 2) == 0);
`else
      check("tiebreak_data_gnt", data_gnt_o, 1);
`endif
    end
    do_reset();

    // Randomized traffic, with one reset landing mid-transaction.
    for (int n = 0; n < 3000; n++) begin
      bit rv;
      rv = (m_tags.size() > 0) && ($urandom_range(0, 99) < 45);
      step($urandom_range(0, 99) < 40, $urandom, $urandom_range(0, 99) < 40, $urandom,
           1'($urandom), 4'($urandom), $urandom,
           $urandom_range(0, 99) < 60, rv, $urandom, ($urandom_range(0, 9) == 0));
      if (n == 1500) do_reset();
    end
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
